// File: rtl/cdb_pkg.sv
// ============================================================================
// Module      : cdb_pkg
// Description : Shared CDB types: FU identifiers, FU count, broadcast entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_pkg;

   typedef enum logic [2:0] {
      FU_ALU = 3'd0,
      FU_BR  = 3'd1,
      FU_MUL = 3'd2,
      FU_DIV = 3'd3,
      FU_MEM = 3'd4
   } fu_id_e;

   localparam int NUM_FU = 5;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic [2:0]  rob_idx;
      fu_id_e      src;
   } cdb_entry_t;

   // Round-robin successor of the winning requester.
   function automatic int next_ptr(input int win, input int n);
      return (win >= n - 1) ? 0 : win + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Generic round-robin one-hot arbiter; search starts at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_win_idx
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      o_grant   = '0;
      o_win_idx = '0;
      found     = 1'b0;
      idx       = '0;
      // Walk ptr, ptr+1 ... with wrap; the first valid requester wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_en && !found && i_req[idx]) begin
            found        = 1'b1;
            o_grant[idx] = 1'b1;
            o_win_idx    = idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin CDB arbiter with registered one-cycle broadcast.
//               Optional macro CDB_STALL_CNT_EN adds per-FU stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ   = NUM_FU,
   parameter int DATA_W    = 32,
   parameter int ROB_IDX_W = 3
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   input  logic [NUM_REQ*DATA_W-1:0]      req_data_in,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   input  logic                           flush_in,
   output logic                           cdb_valid_out,
   output logic [DATA_W-1:0]              cdb_data_out,
   output logic [ROB_IDX_W-1:0]           cdb_rob_idx_out,
   output logic [$clog2(NUM_REQ)-1:0]     cdb_src_out
`ifdef CDB_STALL_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]          stall_cnt_out
`endif
);

   localparam int SRC_W = $clog2(NUM_REQ);

   logic [SRC_W-1:0]     r_ptr;
   logic [SRC_W-1:0]     w_win_idx;
   logic [NUM_REQ-1:0]   w_grant;
   logic                 w_arb_en;
   logic                 w_xfer;
   logic [DATA_W-1:0]    w_win_data;
   logic [ROB_IDX_W-1:0] w_win_rob;

   logic                 r_cdb_valid;
   logic [DATA_W-1:0]    r_cdb_data;
   logic [ROB_IDX_W-1:0] r_cdb_rob;
   logic [SRC_W-1:0]     r_cdb_src;

   // Grants are suppressed while reset is held and during a flush.
   assign w_arb_en = rst_n_in & ~flush_in;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (SRC_W)
   ) u_rr_arbiter (
      .i_req     (req_valid_in),
      .i_ptr     (r_ptr),
      .i_en      (w_arb_en),
      .o_grant   (w_grant),
      .o_win_idx (w_win_idx)
   );

   assign req_ready_out = w_grant;
   assign w_xfer        = |w_grant;
   assign w_win_data    = req_data_in[w_win_idx*DATA_W +: DATA_W];
   assign w_win_rob     = req_rob_idx_in[w_win_idx*ROB_IDX_W +: ROB_IDX_W];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_ptr       <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_data  <= '0;
         r_cdb_rob   <= '0;
         r_cdb_src   <= '0;
      end else begin
         r_cdb_valid <= w_xfer;
         if (w_xfer) begin
            r_ptr      <= SRC_W'(next_ptr(int'(w_win_idx), NUM_REQ));
            r_cdb_data <= w_win_data;
            r_cdb_rob  <= w_win_rob;
            r_cdb_src  <= w_win_idx;
         end
      end
   end

   assign cdb_valid_out   = r_cdb_valid;
   assign cdb_data_out    = r_cdb_data;
   assign cdb_rob_idx_out = r_cdb_rob;
   assign cdb_src_out     = r_cdb_src;

`ifdef CDB_STALL_CNT_EN
   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
         logic [15:0] r_cnt;
         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               r_cnt <= '0;
            end else if (req_valid_in[i] && !req_ready_out[i] && (r_cnt != 16'hFFFF)) begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
         assign stall_cnt_out[i*16 +: 16] = r_cnt;
      end
   endgenerate
`endif

endmodule

`default_nettype wire
